dmm_top: RTL and testbench
==========================

DMM_TOP -- requirements
Module: dmm_top

Interface
REQ-001 Parameters: none; pool size 64 units and 8 pointer registers are fixed constants.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 malloc  input  1  single-cycle allocate strobe.
REQ-005 free  input  1  single-cycle release strobe.
REQ-006 mack  output  1  allocate-done pulse, registered, high exactly one cycle.
REQ-007 frack  output  1  free-done pulse, registered, high exactly one cycle.
REQ-008 requestedmemsize  input  6  allocation size in units (0..63).
REQ-009 regmips  input  3  pointer-register index for the malloc destination or the free source.

Function
REQ-010 Internal state: 64-bit occupancy map alloc_map (bit=1 means used), plus 8-entry table with reg_base[5:0], reg_size[5:0] and reg_valid per entry.
REQ-011 FSM states: IDLE, SEARCH, UPDATE, RELEASE, ACK.
REQ-012 In IDLE, on the edge where malloc=1, requestedmemsize and regmips are latched; a nonzero size goes to SEARCH with scan index 0 and run count 0, and size 0 goes to UPDATE as a failure.
REQ-013 SEARCH examines one map bit per cycle: free bit increments the run count, used bit clears it.
REQ-014 When the run count reaches the size at bit i, the FSM goes to UPDATE with base = i-size+1 (first-fit).
REQ-015 If bit 63 is examined without a match, the FSM goes to UPDATE as a failure.
REQ-016 On UPDATE success: map bits base..base+size-1 are set and entry[regmips] is written with {base, size, valid=1}.
REQ-017 On UPDATE failure: entry[regmips].valid is cleared and the map is unchanged.
REQ-018 UPDATE always goes to ACK with mack=1.
REQ-019 Malloc latency: with success at base b and size s, mack is high between edges b+s+1 and b+s+2 after the sampling edge 0; on failure, between edges 65 and 66; for size 0, between edges 1 and 2.
REQ-020 Malloc to an entry that is already valid overwrites that entry; the old block stays allocated (no implicit free).
REQ-021 In IDLE, on free=1 (and malloc=0), regmips is latched and the FSM goes to RELEASE.
REQ-022 In RELEASE, if the entry is valid, map bits base..base+size-1 and entry valid are cleared; if the entry is invalid, nothing changes.
REQ-023 RELEASE then goes to ACK with frack=1, so frack is high between edges 1 and 2 after the sampling edge.
REQ-024 ACK lasts one cycle, then IDLE; mack and frack are never high together.
REQ-025 Simultaneous malloc and free in IDLE: malloc is served and free is dropped.
REQ-026 Strobes arriving outside IDLE are ignored (not queued).
REQ-027 Range masks are computed in 7-bit arithmetic so base+size never wraps past bit 63.

Reset
REQ-028 While reset=1 at a rising edge: state IDLE, alloc_map=0, all reg_valid=0, reg_base/reg_size=0, mack=0, frack=0.
REQ-029 Reset mid-operation abandons the request with no ack, and reset overrides any strobe in the same cycle.

Structure
REQ-030 Package dmm_pkg holds POOL_UNITS=64, NUM_REGS=8, the width constants and the FSM state enum.
REQ-031 One sub-module, dmm_reg_table, holds the 8-entry base/size/valid table with one write port and one read port.
REQ-032 The FSM, scanner and map live in dmm_top.
REQ-033 alloc_map, reg_base, reg_size and reg_valid are hierarchically visible for checking.

Verification
REQ-034 Reset, then malloc with size=5 and regmips=2 -> mack after 6 cycles; map bits 0-4 set; entry2={0,5,valid}.
REQ-035 Then malloc with size=10 and regmips=3 -> entry3 base=5; map bits 0-14 set.
REQ-036 Free regmips=2 -> frack 1 cycle later, bits 0-4 clear; then malloc size=3 regmips=4 -> base 0 (first-fit reuse).
REQ-037 Malloc size=63 regmips=0 after a size-5 block exists -> failure: mack at edge 65, entry0 invalid, map unchanged; separately, malloc size=0 -> mack at edge 1, entry invalid.
REQ-038 Free on an invalid entry -> frack, no map change.
REQ-039 Simultaneous malloc+free -> only mack; strobes during SEARCH are ignored.
REQ-040 Reset asserted mid-SEARCH -> no mack, map=0.

Source files
------------

// File: rtl/dmm_pkg.sv
// Shared constants, state encoding and the range-mask helper for the
// dynamic memory manager.
package dmm_pkg;

  localparam int POOL_UNITS = 64;
  localparam int NUM_REGS   = 8;
  localparam int UNIT_W     = 6;
  localparam int IDX_W      = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    UPDATE,
    RELEASE,
    ACK
  } state_t;

  // Bounds are widened to 7 bits so base+size can reach 64 without wrapping.
  function automatic logic [POOL_UNITS-1:0] range_mask(input logic [UNIT_W-1:0] base,
                                                       input logic [UNIT_W-1:0] size);
    logic [UNIT_W:0] lo;
    logic [UNIT_W:0] hi;
    logic [POOL_UNITS-1:0] m;
    lo = {1'b0, base};
    hi = lo + {1'b0, size};
    m  = '0;
    for (int i = 0; i < POOL_UNITS; i++) begin
      m[i] = (7'(i) >= lo) && (7'(i) < hi);
    end
    return m;
  endfunction

endpackage

// File: rtl/dmm_reg_table.sv
// Pointer-register table: per-entry base, size and valid flag, with one
// synchronous write port and one combinational read port.
module dmm_reg_table
  import dmm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [UNIT_W-1:0] wbase,
  input  logic [UNIT_W-1:0] wsize,
  input  logic              wvalid,
  input  logic [IDX_W-1:0]  raddr,
  output logic [UNIT_W-1:0] rbase,
  output logic [UNIT_W-1:0] rsize,
  output logic              rvalid
);

  logic [UNIT_W-1:0] reg_base  [NUM_REGS];
  logic [UNIT_W-1:0] reg_size  [NUM_REGS];
  logic              reg_valid [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_base[i]  <= '0;
        reg_size[i]  <= '0;
        reg_valid[i] <= 1'b0;
      end
    end else if (we) begin
      reg_base[waddr]  <= wbase;
      reg_size[waddr]  <= wsize;
      reg_valid[waddr] <= wvalid;
    end
  end

  assign rbase  = reg_base[raddr];
  assign rsize  = reg_size[raddr];
  assign rvalid = reg_valid[raddr];

endmodule

// File: rtl/dmm_top.sv
// First-fit allocator over a 64-unit pool: a bit-serial scanner finds a run of
// free units, and the FSM commits or releases blocks named by pointer registers.
module dmm_top
  import dmm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              malloc,
  input  logic              free,
  input  logic [UNIT_W-1:0] requestedmemsize,
  input  logic [IDX_W-1:0]  regmips,
  output logic              mack,
  output logic              frack
);

  state_t                state;
  logic [POOL_UNITS-1:0] alloc_map;
  logic [UNIT_W-1:0]     req_size;
  logic [IDX_W-1:0]      req_idx;
  logic [UNIT_W-1:0]     scan_idx;
  logic [UNIT_W-1:0]     run_cnt;
  logic [UNIT_W-1:0]     found_base;
  logic                  found_ok;

  logic                  tbl_we;
  logic [UNIT_W-1:0]     tbl_base;
  logic [UNIT_W-1:0]     tbl_size;
  logic                  tbl_valid;
  logic [UNIT_W-1:0]     rd_base;
  logic [UNIT_W-1:0]     rd_size;
  logic                  rd_valid;

  dmm_reg_table u_table (
    .clk    (clk),
    .reset  (reset),
    .we     (tbl_we),
    .waddr  (req_idx),
    .wbase  (tbl_base),
    .wsize  (tbl_size),
    .wvalid (tbl_valid),
    .raddr  (req_idx),
    .rbase  (rd_base),
    .rsize  (rd_size),
    .rvalid (rd_valid)
  );

  // A failed malloc keeps the old base/size but drops the valid flag.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_base  = rd_base;
    tbl_size  = rd_size;
    tbl_valid = 1'b0;
    case (state)
      UPDATE: begin
        tbl_we = 1'b1;
        if (found_ok) begin
          tbl_base  = found_base;
          tbl_size  = req_size;
          tbl_valid = 1'b1;
        end
      end
      RELEASE: tbl_we = rd_valid;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alloc_map  <= '0;
      req_size   <= '0;
      req_idx    <= '0;
      scan_idx   <= '0;
      run_cnt    <= '0;
      found_base <= '0;
      found_ok   <= 1'b0;
      mack       <= 1'b0;
      frack      <= 1'b0;
    end else begin
      mack  <= 1'b0;
      frack <= 1'b0;
      case (state)
        IDLE: begin
          if (malloc) begin
            req_size <= requestedmemsize;
            req_idx  <= regmips;
            scan_idx <= '0;
            run_cnt  <= '0;
            found_ok <= 1'b0;
            state    <= (requestedmemsize == '0) ? UPDATE : SEARCH;
          end else if (free) begin
            req_idx <= regmips;
            state   <= RELEASE;
          end
        end
        SEARCH: begin
          if (!alloc_map[scan_idx] && (run_cnt + 6'd1 == req_size)) begin
            found_ok   <= 1'b1;
            found_base <= scan_idx - req_size + 6'd1;
            state      <= UPDATE;
          end else begin
            run_cnt <= alloc_map[scan_idx] ? '0 : run_cnt + 6'd1;
            if (scan_idx == 6'd63) begin
              state <= UPDATE;
            end else begin
              scan_idx <= scan_idx + 6'd1;
            end
          end
        end
        UPDATE: begin
          if (found_ok) begin
            alloc_map <= alloc_map | range_mask(found_base, req_size);
          end
          mack  <= 1'b1;
          state <= ACK;
        end
        RELEASE: begin
          if (rd_valid) begin
            alloc_map <= alloc_map & ~range_mask(rd_base, rd_size);
          end
          frack <= 1'b1;
          state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmm_top.sv
// Directed bench for dmm_top: each request checks ack latency, ack exclusivity,
// the occupancy map and the pointer-register table against hand-derived values.
module tb_dmm_top;

  logic       clk = 1'b0;
  logic       reset;
  logic       malloc;
  logic       free;
  logic [5:0] requestedmemsize;
  logic [2:0] regmips;
  logic       mack;
  logic       frack;

  int vectors = 0;
  int miscompares = 0;

  dmm_top dut (
    .clk              (clk),
    .reset            (reset),
    .malloc           (malloc),
    .free             (free),
    .requestedmemsize (requestedmemsize),
    .regmips          (regmips),
    .mack             (mack),
    .frack            (frack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_entry(input string tag, input int idx, input logic [5:0] base,
                             input logic [5:0] size, input logic valid);
    checkOutput({tag, ".valid"}, 64'(dut.u_table.reg_valid[idx]), 64'(valid));
    if (valid) begin
      checkOutput({tag, ".base"}, 64'(dut.u_table.reg_base[idx]), 64'(base));
      checkOutput({tag, ".size"}, 64'(dut.u_table.reg_size[idx]), 64'(size));
    end
  endtask

  // Issue one request and measure edges until its ack; inject_edge>0 pulses
  // malloc+free on that edge while the request is still in flight.
  task automatic applyStimulus(input string tag, input logic m, input logic f,
                               input logic [5:0] size, input logic [2:0] idx,
                               input int exp_lat, input int inject_edge);
    int   lat;
    logic wrong_ack;
    lat       = -1;
    wrong_ack = 1'b0;
    @(negedge clk);
    malloc = m; free = f; requestedmemsize = size; regmips = idx;
    @(posedge clk); #1;
    malloc = 1'b0; free = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      if (n == inject_edge) begin
        malloc = 1'b1; free = 1'b1; regmips = 3'd5; requestedmemsize = 6'd1;
      end
      @(posedge clk); #1;
      malloc = 1'b0; free = 1'b0;
      if (m ? frack : mack) wrong_ack = 1'b1;
      if (m ? mack : frack) begin
        lat = n;
        break;
      end
    end
    checkOutput({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, ".other_ack"}, 64'(wrong_ack), 64'd0);
    if (lat >= 0) begin
      @(posedge clk); #1;
      checkOutput({tag, ".pulse_width"}, 64'(mack | frack), 64'd0);
    end
  endtask

  initial begin
    int seen_mack;
    reset = 1'b1; malloc = 1'b0; free = 1'b0; requestedmemsize = '0; regmips = '0;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset.map", dut.alloc_map, 64'd0);
    checkOutput("reset.mack", 64'(mack), 64'd0);
    checkOutput("reset.frack", 64'(frack), 64'd0);
    check_entry("reset.e2", 2, 6'd0, 6'd0, 1'b0);
    @(negedge clk); reset = 1'b0;

    applyStimulus("m5r2", 1'b1, 1'b0, 6'd5, 3'd2, 6, 0);
    checkOutput("m5r2.map", dut.alloc_map, 64'h1F);
    check_entry("m5r2.e2", 2, 6'd0, 6'd5, 1'b1);

    applyStimulus("m10r3", 1'b1, 1'b0, 6'd10, 3'd3, 16, 0);
    checkOutput("m10r3.map", dut.alloc_map, 64'h7FFF);
    check_entry("m10r3.e3", 3, 6'd5, 6'd10, 1'b1);

    applyStimulus("f2", 1'b0, 1'b1, 6'd0, 3'd2, 1, 0);
    checkOutput("f2.map", dut.alloc_map, 64'h7FE0);
    check_entry("f2.e2", 2, 6'd0, 6'd0, 1'b0);

    applyStimulus("m3r4", 1'b1, 1'b0, 6'd3, 3'd4, 4, 0);
    checkOutput("m3r4.map", dut.alloc_map, 64'h7FE7);
    check_entry("m3r4.e4", 4, 6'd0, 6'd3, 1'b1);

    applyStimulus("m63fail", 1'b1, 1'b0, 6'd63, 3'd0, 65, 0);
    checkOutput("m63fail.map", dut.alloc_map, 64'h7FE7);
    check_entry("m63fail.e0", 0, 6'd0, 6'd0, 1'b0);

    applyStimulus("m0r3", 1'b1, 1'b0, 6'd0, 3'd3, 1, 0);
    checkOutput("m0r3.map", dut.alloc_map, 64'h7FE7);
    check_entry("m0r3.e3", 3, 6'd0, 6'd0, 1'b0);

    applyStimulus("f3inv", 1'b0, 1'b1, 6'd0, 3'd3, 1, 0);
    checkOutput("f3inv.map", dut.alloc_map, 64'h7FE7);

    applyStimulus("m2r4ow", 1'b1, 1'b0, 6'd2, 3'd4, 6, 0);
    checkOutput("m2r4ow.map", dut.alloc_map, 64'h7FFF);
    check_entry("m2r4ow.e4", 4, 6'd3, 6'd2, 1'b1);

    applyStimulus("mf_both", 1'b1, 1'b1, 6'd1, 3'd5, 17, 0);
    checkOutput("mf_both.map", dut.alloc_map, 64'hFFFF);
    check_entry("mf_both.e5", 5, 6'd15, 6'd1, 1'b1);

    applyStimulus("m4inject", 1'b1, 1'b0, 6'd4, 3'd6, 21, 3);
    checkOutput("m4inject.map", dut.alloc_map, 64'hF_FFFF);
    check_entry("m4inject.e6", 6, 6'd16, 6'd4, 1'b1);
    check_entry("m4inject.e5", 5, 6'd15, 6'd1, 1'b1);

    // Reset in the middle of a search must abandon the request silently.
    @(negedge clk);
    malloc = 1'b1; requestedmemsize = 6'd8; regmips = 3'd7;
    @(posedge clk); #1;
    malloc = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; malloc = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; malloc = 1'b0;
    seen_mack = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk); #1;
      if (mack) seen_mack++;
    end
    checkOutput("rst_mid.mack_count", 64'(seen_mack), 64'd0);
    checkOutput("rst_mid.map", dut.alloc_map, 64'd0);
    check_entry("rst_mid.e7", 7, 6'd0, 6'd0, 1'b0);
    check_entry("rst_mid.e5", 5, 6'd0, 6'd0, 1'b0);

    applyStimulus("m63r1", 1'b1, 1'b0, 6'd63, 3'd1, 64, 0);
    checkOutput("m63r1.map", dut.alloc_map, 64'h7FFF_FFFF_FFFF_FFFF);
    check_entry("m63r1.e1", 1, 6'd0, 6'd63, 1'b1);

    applyStimulus("m1top", 1'b1, 1'b0, 6'd1, 3'd2, 65, 0);
    checkOutput("m1top.map", dut.alloc_map, 64'hFFFF_FFFF_FFFF_FFFF);
    check_entry("m1top.e2", 2, 6'd63, 6'd1, 1'b1);

    applyStimulus("f1", 1'b0, 1'b1, 6'd0, 3'd1, 1, 0);
    checkOutput("f1.map", dut.alloc_map, 64'h8000_0000_0000_0000);
    check_entry("f1.e1", 1, 6'd0, 6'd0, 1'b0);

    applyStimulus("f0inv", 1'b0, 1'b1, 6'd0, 3'd0, 1, 0);
    checkOutput("f0inv.map", dut.alloc_map, 64'h8000_0000_0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
